// File: rtl/audio_pkg.sv
// Shared types for the I2S sample transmitter: default stereo pair layout and serializer states.
package audio_pkg;

  localparam int AUDIO_SAMPLE_W = 16;

  typedef struct packed {
    logic signed [AUDIO_SAMPLE_W-1:0] l;
    logic signed [AUDIO_SAMPLE_W-1:0] r;
  } stereo_sample_t;

  typedef enum logic {
    IDLE,
    RUN
  } i2s_state_e;

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous FIFO of stereo pairs with fall-through read data and an occupancy count.
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter type T     = stereo_sample_t,
  parameter int  DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  T                       wr_data,
  output T                       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);

endmodule

// File: rtl/i2s_sample_tx.sv
// Stereo PCM to Philips I2S serializer with a small sample FIFO.
// Define I2S_UNDERRUN_HOLD_EN to repeat the last popped pair on underrun instead of sending silence.
module i2s_sample_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int SCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic signed [SAMPLE_W-1:0]    sample_l,
  input  logic signed [SAMPLE_W-1:0]    sample_r,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          busy,
  output logic                          i2s_sclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sda
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BIT_W   = $clog2(FRAME_W);

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] l;
    logic signed [SAMPLE_W-1:0] r;
  } pair_t;

  i2s_state_e          state;
  i2s_state_e          state_next;
  logic [DIV_W-1:0]    div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [BIT_W-1:0]    next_bit;
  logic [FRAME_W-1:0]  sh;
  logic                stopping;
  logic                tick;
  logic                fall;
  logic                frame_end;
  logic                load;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  pair_t               wr_pair;
  pair_t               rd_pair;
  pair_t               fill;
  pair_t               frame_in;

  assign wr_pair.l = sample_l;
  assign wr_pair.r = sample_r;
  assign push      = sample_valid && sample_ready;
  assign pop       = load && !empty;

  audio_sample_fifo #(
    .T     (pair_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_pair),
    .rd_data (rd_pair),
    .full    (full),
    .empty   (empty),
    .level   (fifo_level)
  );

  assign sample_ready = !full;
  assign busy         = (state == RUN);

  assign tick      = (div_cnt == DIV_W'(SCLK_DIV - 1));
  assign fall      = tick && i2s_sclk;
  assign next_bit  = (bit_cnt == BIT_W'(FRAME_W - 1)) ? '0 : bit_cnt + 1'b1;
  assign frame_end = (next_bit == '0);

`ifdef I2S_UNDERRUN_HOLD_EN
  pair_t last_pair;

  always_ff @(posedge clk) begin
    if (rst)      last_pair <= '0;
    else if (pop) last_pair <= rd_pair;
  end

  assign fill = last_pair;
`else
  assign fill = '0;
`endif

  assign frame_in = empty ? fill : rd_pair;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // A stop request only takes effect at the slot-0 boundary, so the last frame always completes.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (fall) begin
          if (stopping)                state_next = IDLE;
          else if (frame_end && enable) load       = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      stopping  <= 1'b0;
      underrun  <= 1'b0;
      i2s_sclk  <= 1'b0;
      i2s_lrclk <= 1'b0;
      i2s_sda   <= 1'b0;
    end else begin
      underrun <= load && empty;
      if (state_next == IDLE) begin
        div_cnt   <= '0;
        bit_cnt   <= '0;
        sh        <= '0;
        stopping  <= 1'b0;
        i2s_sclk  <= 1'b0;
        i2s_lrclk <= 1'b0;
        i2s_sda   <= 1'b0;
      end else if (state == IDLE) begin
        // Entering RUN: slot 0 of the first frame has no previous R LSB to send.
        div_cnt   <= '0;
        bit_cnt   <= '0;
        sh        <= frame_in;
        stopping  <= 1'b0;
        i2s_sclk  <= 1'b0;
        i2s_lrclk <= 1'b0;
        i2s_sda   <= 1'b0;
      end else begin
        div_cnt <= tick ? '0 : div_cnt + 1'b1;
        if (tick) i2s_sclk <= ~i2s_sclk;
        if (fall) begin
          bit_cnt   <= next_bit;
          i2s_lrclk <= (next_bit >= BIT_W'(SAMPLE_W));
          i2s_sda   <= sh[FRAME_W-1];
          sh        <= load ? frame_in : (sh << 1);
          if (frame_end && !enable) stopping <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_sample_tx.sv
// Self-checking bench for i2s_sample_tx: pin-level I2S receiver with a pair scoreboard plus directed sequences.
module tb_i2s_sample_tx;

  localparam int SW  = 16;
  localparam int DIV = 2;
  localparam int FD  = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 enable = 1'b0;
  logic signed [SW-1:0] sample_l = '0;
  logic signed [SW-1:0] sample_r = '0;
  logic                 sample_valid = 1'b0;
  logic                 sample_ready;
  logic [3:0]           fifo_level;
  logic                 underrun;
  logic                 busy;
  logic                 i2s_sclk;
  logic                 i2s_lrclk;
  logic                 i2s_sda;

  int errors = 0;
  int checks = 0;

  i2s_sample_tx #(
    .SAMPLE_W   (SW),
    .SCLK_DIV   (DIV),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_l     (sample_l),
    .sample_r     (sample_r),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .fifo_level   (fifo_level),
    .underrun     (underrun),
    .busy         (busy),
    .i2s_sclk     (i2s_sclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sda      (i2s_sda)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // Scoreboard / receiver model, sampled 1 time unit after each rising clk edge.
  logic [31:0] q[$];
  logic [31:0] exp_cur = '0, exp_prev = '0, last_pop = '0, word = '0, fillv;
  bit          have_cur = 0, have_prev = 0;
  logic        p_sclk = 0, p_lrclk = 0, p_busy = 0, rdy_q = 0, uexp;
  int          slot = 0, frames = 0, uruns = 0, lr_err = 0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      q.delete();
      have_cur = 0; have_prev = 0; last_pop = '0; slot = 0;
      p_sclk = 0; p_lrclk = 0; p_busy = 0;
    end else begin
      if (underrun) uruns++;
      if ((!p_busy && busy) || (busy && p_sclk && !i2s_sclk && p_lrclk && !i2s_lrclk)) begin
        exp_prev  = exp_cur;
        have_prev = have_cur && p_busy;
        slot      = 0;
        if (enable) begin
`ifdef I2S_UNDERRUN_HOLD_EN
          fillv = last_pop;
`else
          fillv = '0;
`endif
          if (q.size() == 0) begin
            exp_cur = fillv; uexp = 1'b1;
          end else begin
            exp_cur = q.pop_front(); last_pop = exp_cur; uexp = 1'b0;
          end
          have_cur = 1;
          chk("underrun_at_frame_start", underrun, uexp);
        end else begin
          have_cur = 0;
          chk("no_underrun_on_stop", underrun, 0);
        end
      end else if (underrun) begin
        chk("underrun_mid_frame", underrun, 0);
      end
      if (!p_sclk && i2s_sclk && slot < 32) begin
        if (slot == 0) begin
          if (have_prev) begin
            chk("frame_data", {word[31:1], i2s_sda}, exp_prev);
            frames++;
          end else begin
            chk("first_slot0_sda", i2s_sda, 0);
          end
        end else begin
          word[32-slot] = i2s_sda;
        end
        if (i2s_lrclk !== (slot >= 16)) lr_err++;
        slot++;
      end
      if (sample_valid && rdy_q) q.push_back({sample_l, sample_r});
      p_sclk = i2s_sclk; p_lrclk = i2s_lrclk; p_busy = busy;
    end
    rdy_q = sample_ready;
  end

  task automatic push_pair(input logic [15:0] l, input logic [15:0] r, input int limit, output bit ok);
    int n = 0;
    @(negedge clk);
    sample_l = l; sample_r = r; sample_valid = 1'b1;
    while (!sample_ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    ok = sample_ready;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_rise(output int gap);
    logic p;
    gap = 0;
    p = i2s_sclk;
    while (gap < 40) begin
      @(negedge clk);
      gap++;
      if (!p && i2s_sclk) break;
      p = i2s_sclk;
    end
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  task automatic wait_frame_start();
    logic p;
    int   n = 0;
    p = i2s_lrclk;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (p && !i2s_lrclk) break;
      p = i2s_lrclk;
    end
    chk("frame_start_seen", n < 300, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_pins_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sclk"}, i2s_sclk, 0);
    chk({tag, "_lrclk"}, i2s_lrclk, 0);
    chk({tag, "_sda"}, i2s_sda, 0);
    chk({tag, "_underrun"}, underrun, 0);
  endtask

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic [3:0]  level;
    logic        ready;
  } fill_vec_t;

  fill_vec_t   tv [8];
  bit          ok;
  int          g, bad_gaps, gap_sum, u0, f0, l0;
  logic [32:0] sda_cap, lr_cap;
  logic        acc;

  initial begin
    tv[0] = '{16'h1111, 16'hEEEE, 4'd1, 1'b1};
    tv[1] = '{16'h8000, 16'h7FFF, 4'd2, 1'b1};
    tv[2] = '{16'hFFFF, 16'h0001, 4'd3, 1'b1};
    tv[3] = '{16'h0000, 16'hFFFF, 4'd4, 1'b1};
    tv[4] = '{16'h5A5A, 16'hA5A5, 4'd5, 1'b1};
    tv[5] = '{16'h1234, 16'h5678, 4'd6, 1'b1};
    tv[6] = '{16'hCAFE, 16'hBEEF, 4'd7, 1'b1};
    tv[7] = '{16'h0F0F, 16'hF0F0, 4'd8, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_pins_idle("reset");
    chk("reset_ready", sample_ready, 1);
    chk("reset_level", fifo_level, 0);

    // Single frame: A5C3 / 0F0F, sclk period and frame length
    push_pair(16'hA5C3, 16'h0F0F, 4, ok);
    chk("t1_level_after_push", fifo_level, 1);
    enable = 1'b1;
    @(negedge clk);
    chk("t1_busy", busy, 1);
    chk("t1_level_after_pop", fifo_level, 0);
    chk("t1_no_underrun", underrun, 0);
    bad_gaps = 0; gap_sum = 0; sda_cap = '0; lr_cap = '0;
    for (int s = 0; s < 33; s++) begin
      wait_rise(g);
      if (s == 0) chk("t1_first_rise_gap", g, 2);
      else begin
        gap_sum += g;
        if (g != 2 * DIV) bad_gaps++;
      end
      sda_cap = {sda_cap[31:0], i2s_sda};
      lr_cap  = {lr_cap[31:0], i2s_lrclk};
    end
    chk("t1_sda_slots", sda_cap, {1'b0, 32'hA5C30F0F});
    chk("t1_lrclk_slots", lr_cap, {32'h0000FFFF, 1'b0});
    chk("t1_sclk_period", bad_gaps, 0);
    chk("t1_frame_clks", gap_sum, 128);
    enable = 1'b0;
    wait_idle(400);

    // FIFO fill table: level/ready after each push, then a stalled 9th push
    for (int i = 0; i < 8; i++) begin
      push_pair(tv[i].l, tv[i].r, 4, ok);
      chk("t2_accepted", ok, 1);
      chk("t2_level", fifo_level, tv[i].level);
      chk("t2_ready", sample_ready, tv[i].ready);
    end
    push_pair(16'h9999, 16'h6666, 6, ok);
    chk("t2_ninth_stalls", ok, 0);
    chk("t2_level_full", fifo_level, 8);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("t2_first_pop", fifo_level, 7);
    repeat (127) @(negedge clk);
    chk("t2_level_before_frame2", fifo_level, 7);
    @(negedge clk);
    chk("t2_second_pop", fifo_level, 6);

    // Continuous push at one pair per frame for 100 frames
    u0 = uruns; f0 = frames;
    for (int i = 0; i < 100; i++) begin
      push_pair(16'($urandom), 16'($urandom), 4, ok);
      repeat (126) @(negedge clk);
    end
    chk("t6_no_underrun", uruns - u0, 0);
    chk("t6_frames_compared", (frames - f0) >= 100, 1);

    // Drop enable in the left slot: frame completes, slot 0 sent, then idle with FIFO untouched
    wait_frame_start();
    repeat (20) @(negedge clk);
    enable = 1'b0;
    l0 = q.size();
    chk("t4_level_matches_model", fifo_level, l0);
    repeat (111) @(negedge clk);
    chk("t4_busy_through_slot0", busy, 1);
    @(negedge clk);
    chk_pins_idle("t4_stopped");
    chk("t4_fifo_unchanged", fifo_level, l0);

    // Underrun with empty FIFO, then one pair followed by an underrun frame
    do_reset();
    @(negedge clk);
    chk("t3_level_after_reset", fifo_level, 0);
    enable = 1'b1;
    @(negedge clk);
    chk("t3_underrun_pulse", underrun, 1);
    acc = 1'b0;
    @(negedge clk);
    chk("t3_underrun_one_clk", underrun, 0);
    repeat (126) begin
      @(negedge clk);
      acc |= i2s_sda;
    end
    @(negedge clk);
    chk("t3_silent_frame", acc, 0);
    chk("t3_underrun_next_frame", underrun, 1);
    push_pair(16'h1234, 16'h5678, 4, ok);
    repeat (400) @(negedge clk);
    enable = 1'b0;
    wait_idle(600);

    // Reset mid-frame at slot 20 with 3 pairs still queued
    for (int i = 0; i < 4; i++) push_pair(16'(16'h0100 + i), 16'(16'h0200 + i), 4, ok);
    enable = 1'b1;
    repeat (81) @(negedge clk);
    chk("t5_right_slot", i2s_lrclk, 1);
    chk("t5_level_before_rst", fifo_level, 3);
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk_pins_idle("t5_reset");
    chk("t5_level_cleared", fifo_level, 0);
    chk("t5_ready", sample_ready, 1);
    rst = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("t5_fifo_discarded", underrun, 1);
    enable = 1'b0;
    wait_idle(600);

    chk("lrclk_per_slot", lr_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
